// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_scoreboard_unit_pkg
// Shared types for the pipeline hazard controller:
//   - slot_flags_t : per-slot scoreboard flags (valid, reg_write, mem_read);
//                    the dest field width comes from the REG_ADDR_W parameter
//   - hz_state_t   : priority-resolved control state for the current cycle
//   - hz_ctrl_t    : bundle of the six pipeline control outputs
//   - resolve_state / state_ctrl : priority resolution and output decode
package hazard_scoreboard_unit_pkg;

  localparam int SLOT_FLAG_W = 3;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
  } slot_flags_t;

  typedef enum logic [2:0] {
    FREEZE = 3'd0,
    BMISS  = 3'd1,
    DSTALL = 3'd2,
    JMISS  = 3'd3,
    IWAIT  = 3'd4,
    RUN    = 3'd5
  } hz_state_t;

  typedef struct packed {
    logic stall_ifid;
    logic flush_ifid;
    logic flush_idex;
    logic freeze_pipe;
    logic pc_write;
    logic ir_write;
  } hz_ctrl_t;

  // Outputs presented while reset_n is low: nothing advances and both
  // front-end pipeline registers are loaded with bubbles.
  localparam hz_ctrl_t RESET_CTRL = '{
    stall_ifid: 1'b0, flush_ifid: 1'b1, flush_idex: 1'b1,
    freeze_pipe: 1'b0, pc_write: 1'b0, ir_write: 1'b0
  };

  // Highest priority first. A data-memory wait freezes everything, so a
  // coinciding miss is dropped and must be re-asserted by its source.
  function automatic hz_state_t resolve_state(
    input logic d_mem_ready,
    input logic i_branch_miss,
    input logic data_stall,
    input logic jump_miss,
    input logic i_mem_ready
  );
    hz_state_t st;
    if (!d_mem_ready)       st = FREEZE;
    else if (i_branch_miss) st = BMISS;   // ID instruction is wrong-path
    else if (data_stall)    st = DSTALL;
    else if (jump_miss)     st = JMISS;
    else if (!i_mem_ready)  st = IWAIT;
    else                    st = RUN;
    return st;
  endfunction

  function automatic hz_ctrl_t state_ctrl(input hz_state_t st);
    hz_ctrl_t c;
    c = '0;
    case (st)
      FREEZE: begin
        c.freeze_pipe = 1'b1;
        c.stall_ifid  = 1'b1;
      end
      BMISS: begin
        c.flush_ifid = 1'b1;
        c.flush_idex = 1'b1;
        c.pc_write   = 1'b1;
        c.ir_write   = 1'b1;
      end
      DSTALL: begin
        c.stall_ifid = 1'b1;
        c.flush_idex = 1'b1;
      end
      JMISS: begin
        c.flush_ifid = 1'b1;
        c.pc_write   = 1'b1;
        c.ir_write   = 1'b1;
      end
      IWAIT: begin
        c.flush_ifid = 1'b1;
      end
      default: begin
        c.pc_write = 1'b1;
        c.ir_write = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if
// Bundle between the control unit / memories (master) and the hazard
// controller (slave).
//   master drives : ID decode fields, jump/branch miss, memory ready, cnt_clear
//   slave drives  : pipeline enables/flushes, pc_write, ir_write, counters
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 2,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_reg_write;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_mem_read;
  logic                  jump_miss;
  logic                  i_branch_miss;
  logic                  i_mem_ready;
  logic                  d_mem_ready;
  logic                  cnt_clear;

  logic                  stall_IFID;
  logic                  flush_IFID;
  logic                  flush_IDEX;
  logic                  freeze_pipe;
  logic                  pc_write;
  logic                  ir_write;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_reg_write,
           id_dest, id_mem_read, jump_miss, i_branch_miss, i_mem_ready,
           d_mem_ready, cnt_clear,
    input  stall_IFID, flush_IFID, flush_IDEX, freeze_pipe, pc_write,
           ir_write, stall_cycles, flush_count
  );

  modport slave (
    input  id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_reg_write,
           id_dest, id_mem_read, jump_miss, i_branch_miss, i_mem_ready,
           d_mem_ready, cnt_clear,
    output stall_IFID, flush_IFID, flush_IDEX, freeze_pipe, pc_write,
           ir_write, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit_sat_counter.sv
// sat_counter
// Event counter that sticks at all-ones. clear wins over inc.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear
//   inc          : count this cycle
//   count        : current value
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (inc && (count_reg != {CNT_W{1'b1}}))
      count_next = count_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// Pipeline hazard controller with a private shift-register scoreboard of
// in-flight destinations (slot0 = EX, slot1 = MEM, slot2 = WB, ...).
// Control outputs are combinational from the scoreboard and current inputs.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : hazard_scoreboard_unit_if.slave (ID fields, misses, memory
//             ready, cnt_clear in; pipeline controls and counters out)
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int DATA_FORWARDING  = 1,
  parameter int REG_ADDR_W       = 2,
  parameter int PIPE_DEPTH       = 3,
  parameter int RF_WRITE_THROUGH = 0,
  parameter int CNT_W            = 16
) (
  input logic                      clk,
  input logic                      reset_n,
  hazard_scoreboard_unit_if.slave  bus
);

  // With a write-through register file the oldest slot's value is already
  // visible to the ID read, so it cannot cause a hazard.
  localparam int NUM_CHECKED = (RF_WRITE_THROUGH != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

  slot_flags_t           sb_flags_reg [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] sb_dest_reg  [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] slot_match;
  logic [PIPE_DEPTH-1:0] slot_checked;
  logic                  data_stall;
  hz_state_t             state;
  hz_ctrl_t              ctrl;
  logic                  advance;
  slot_flags_t           slot0_flags_next;

  // Per-slot RAW match against the sources the ID instruction actually uses.
  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_slot
    assign slot_match[gi] = bus.id_valid
                          & sb_flags_reg[gi].valid
                          & sb_flags_reg[gi].reg_write
                          & ((bus.id_use_rs & (sb_dest_reg[gi] == bus.id_rs))
                           | (bus.id_use_rt & (sb_dest_reg[gi] == bus.id_rt)));
    assign slot_checked[gi] = (gi < NUM_CHECKED) ? 1'b1 : 1'b0;
  end

  // With forwarding only a load still in EX cannot supply its result in time.
  assign data_stall = (DATA_FORWARDING != 0)
                    ? (slot_match[0] & sb_flags_reg[0].mem_read)
                    : (|(slot_match & slot_checked));

  assign state   = resolve_state(bus.d_mem_ready, bus.i_branch_miss, data_stall,
                                 bus.jump_miss, bus.i_mem_ready);
  assign advance = (state != FREEZE);

  // Branch miss squashes the wrong-path ID instruction; a data stall holds
  // it in ID, so in both cases EX receives a bubble. A mispredicted jump
  // still enters because JAL writes its link register.
  always_comb begin
    slot0_flags_next = '0;
    if ((state != BMISS) && (state != DSTALL)) begin
      slot0_flags_next.valid     = bus.id_valid;
      slot0_flags_next.reg_write = bus.id_reg_write;
      slot0_flags_next.mem_read  = bus.id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_flags_reg[i] <= '0;
        sb_dest_reg[i]  <= '0;
      end
    end else if (advance) begin
      sb_flags_reg[0] <= slot0_flags_next;
      sb_dest_reg[0]  <= bus.id_dest;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        sb_flags_reg[i] <= sb_flags_reg[i-1];
        sb_dest_reg[i]  <= sb_dest_reg[i-1];
      end
    end
  end

  always_comb begin
    ctrl = RESET_CTRL;
    if (reset_n)
      ctrl = state_ctrl(state);
  end

  assign bus.stall_IFID  = ctrl.stall_ifid;
  assign bus.flush_IFID  = ctrl.flush_ifid;
  assign bus.flush_IDEX  = ctrl.flush_idex;
  assign bus.freeze_pipe = ctrl.freeze_pipe;
  assign bus.pc_write    = ctrl.pc_write;
  assign bus.ir_write    = ctrl.ir_write;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.cnt_clear),
    .inc     ((state == FREEZE) || (state == DSTALL)),
    .count   (bus.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (bus.cnt_clear),
    .inc     ((state == BMISS) || (state == JMISS)),
    .count   (bus.flush_count)
  );

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit. Four instances see identical stimulus:
//   dut0: forwarding, dut1: no forwarding, dut2: no forwarding + RF
//   write-through, dut3: forwarding with 3-bit counters (saturation only).
// Control outputs packed as {stall_IFID, flush_IFID, flush_IDEX,
// freeze_pipe, pc_write, ir_write}.
module tb_hazard_scoreboard_unit;

  localparam int N_DUT = 4;

  localparam logic [5:0] C_RUN = 6'b000011;
  localparam logic [5:0] C_DST = 6'b101000;
  localparam logic [5:0] C_BMS = 6'b011011;
  localparam logic [5:0] C_JMS = 6'b010011;
  localparam logic [5:0] C_FRZ = 6'b100100;
  localparam logic [5:0] C_IWT = 6'b010000;
  localparam logic [5:0] C_RST = 6'b011000;

  typedef struct packed {
    logic       v;
    logic       use_rs;
    logic       use_rt;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       rw;
    logic [1:0] dest;
    logic       mr;
  } instr_t;

  typedef struct packed {
    instr_t     ins;
    logic       bmiss;
    logic       jmiss;
    logic       imr;
    logic       dmr;
    logic [5:0] e0;
    logic [5:0] e1;
    logic [5:0] e2;
  } stim_t;

  typedef struct {
    string      name;
    int         dut;
    logic [5:0] ctrl;
  } exp_t;

  //                           v   rs  rt  rs     rt     rw  dest   mr
  localparam instr_t NOP    = '0;
  localparam instr_t LW_R1  = {1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b1};
  localparam instr_t ADD_R1 = {1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1, 2'd3, 1'b0};
  localparam instr_t ADI_R2 = {1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0};
  localparam instr_t ADD_R2 = {1'b1, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 2'd3, 1'b0};
  localparam instr_t JAL_R3 = {1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 1'b0};
  localparam instr_t ADD_R3 = {1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 2'd1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic [1:0] id_rs, id_rt, id_dest;
  logic       jump_miss, i_branch_miss, i_mem_ready, d_mem_ready, cnt_clear;

  logic [5:0]  ctrl_w  [N_DUT];
  logic [31:0] stall_w [N_DUT];
  logic [31:0] flush_w [N_DUT];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    localparam int FWD = (gi == 1 || gi == 2) ? 0 : 1;
    localparam int WT  = (gi == 2) ? 1 : 0;
    localparam int CW  = (gi == 3) ? 3 : 16;

    hazard_scoreboard_unit_if #(.REG_ADDR_W(2), .CNT_W(CW)) bus ();

    assign bus.id_valid      = id_valid;
    assign bus.id_use_rs     = id_use_rs;
    assign bus.id_use_rt     = id_use_rt;
    assign bus.id_rs         = id_rs;
    assign bus.id_rt         = id_rt;
    assign bus.id_reg_write  = id_reg_write;
    assign bus.id_dest       = id_dest;
    assign bus.id_mem_read   = id_mem_read;
    assign bus.jump_miss     = jump_miss;
    assign bus.i_branch_miss = i_branch_miss;
    assign bus.i_mem_ready   = i_mem_ready;
    assign bus.d_mem_ready   = d_mem_ready;
    assign bus.cnt_clear     = cnt_clear;

    assign ctrl_w[gi]  = {bus.stall_IFID, bus.flush_IFID, bus.flush_IDEX,
                          bus.freeze_pipe, bus.pc_write, bus.ir_write};
    assign stall_w[gi] = 32'(bus.stall_cycles);
    assign flush_w[gi] = 32'(bus.flush_count);

    hazard_scoreboard_unit #(
      .DATA_FORWARDING (FWD),
      .REG_ADDR_W      (2),
      .PIPE_DEPTH      (3),
      .RF_WRITE_THROUGH(WT),
      .CNT_W           (CW)
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );
  end

  function automatic stim_t st(input instr_t ins, input logic bm, input logic jm,
                               input logic imr, input logic dmr,
                               input logic [5:0] e0, input logic [5:0] e1,
                               input logic [5:0] e2);
    stim_t s;
    s.ins = ins; s.bmiss = bm; s.jmiss = jm; s.imr = imr; s.dmr = dmr;
    s.e0 = e0; s.e1 = e1; s.e2 = e2;
    return s;
  endfunction

  // Applies one cycle of stimulus and queues the expected controls per DUT.
  task automatic drive_cycle(input string name, input stim_t s);
    {id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_reg_write, id_dest, id_mem_read} = s.ins;
    i_branch_miss = s.bmiss;
    jump_miss     = s.jmiss;
    i_mem_ready   = s.imr;
    d_mem_ready   = s.dmr;
    cnt_clear     = 1'b0;
    exp_q.push_back('{name, 0, s.e0});
    exp_q.push_back('{name, 1, s.e1});
    exp_q.push_back('{name, 2, s.e2});
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    {id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_reg_write, id_dest, id_mem_read} = NOP;
    {i_branch_miss, jump_miss, cnt_clear} = 3'b000;
    {i_mem_ready, d_mem_ready} = 2'b11;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    drive_cycle("reset_hold", st(NOP, 0, 0, 1, 1, C_RST, C_RST, C_RST));
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_w[e.dut] !== e.ctrl)
        $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
      else n_pass++;
    end
    for (int d = 0; d < N_DUT; d++) begin
      n_checks++;
      if (stall_w[d] !== 32'd0 || flush_w[d] !== 32'd0)
        $display("FAIL reset_cnt dut%0d got stall=%0d flush=%0d want 0/0", d, stall_w[d], flush_w[d]);
      else n_pass++;
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive_cycle("reset_first", st(NOP, 0, 0, 1, 1, C_RUN, C_RUN, C_RUN));
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_w[e.dut] !== e.ctrl)
        $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t tbl[5];
    exp_t  e;
    int    want[3] = '{1, 3, 2};
    tbl[0] = st(LW_R1,  0, 0, 1, 1, C_RUN, C_RUN, C_RUN);
    tbl[1] = st(ADD_R1, 0, 0, 1, 1, C_DST, C_DST, C_DST);
    tbl[2] = st(ADD_R1, 0, 0, 1, 1, C_RUN, C_DST, C_DST);
    tbl[3] = st(ADD_R1, 0, 0, 1, 1, C_RUN, C_DST, C_RUN);
    tbl[4] = st(NOP,    0, 0, 1, 1, C_RUN, C_RUN, C_RUN);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle($sformatf("load_use[%0d]", i), tbl[i]);
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ctrl_w[e.dut] !== e.ctrl)
          $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (stall_w[d] !== 32'(want[d]))
        $display("FAIL load_use_stall_cycles dut%0d got %0d want %0d", d, stall_w[d], want[d]);
      else n_pass++;
    end
  endtask

  task automatic test_raw_nofwd();
    stim_t tbl[5];
    exp_t  e;
    int    want[3] = '{0, 3, 2};
    tbl[0] = st(ADI_R2, 0, 0, 1, 1, C_RUN, C_RUN, C_RUN);
    tbl[1] = st(ADD_R2, 0, 0, 1, 1, C_RUN, C_DST, C_DST);
    tbl[2] = st(ADD_R2, 0, 0, 1, 1, C_RUN, C_DST, C_DST);
    tbl[3] = st(ADD_R2, 0, 0, 1, 1, C_RUN, C_DST, C_RUN);
    tbl[4] = st(ADD_R2, 0, 0, 1, 1, C_RUN, C_RUN, C_RUN);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle($sformatf("raw_nofwd[%0d]", i), tbl[i]);
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ctrl_w[e.dut] !== e.ctrl)
          $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (stall_w[d] !== 32'(want[d]))
        $display("FAIL raw_stall_cycles dut%0d got %0d want %0d", d, stall_w[d], want[d]);
      else n_pass++;
    end
  endtask

  // Load held in EX across a 4-cycle data-memory wait; a branch miss during
  // the freeze must be ignored, and the load must still be in EX afterwards.
  task automatic test_freeze();
    stim_t tbl[6];
    exp_t  e;
    tbl[0] = st(LW_R1,  0, 0, 1, 1, C_RUN, C_RUN, C_RUN);
    tbl[1] = st(ADD_R1, 0, 0, 1, 0, C_FRZ, C_FRZ, C_FRZ);
    tbl[2] = st(ADD_R1, 1, 0, 1, 0, C_FRZ, C_FRZ, C_FRZ);
    tbl[3] = st(ADD_R1, 0, 0, 1, 0, C_FRZ, C_FRZ, C_FRZ);
    tbl[4] = st(ADD_R1, 0, 0, 1, 0, C_FRZ, C_FRZ, C_FRZ);
    tbl[5] = st(ADD_R1, 0, 0, 1, 1, C_DST, C_DST, C_DST);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle($sformatf("freeze[%0d]", i), tbl[i]);
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ctrl_w[e.dut] !== e.ctrl)
          $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
        else n_pass++;
      end
      if (i == 5) begin
        n_checks++;
        if (stall_w[0] !== 32'd4)
          $display("FAIL freeze_stall_cycles dut0 got %0d want 4", stall_w[0]);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < N_DUT; d++) begin
      n_checks++;
      if (stall_w[d] !== 32'd5 || flush_w[d] !== 32'd0)
        $display("FAIL freeze_counts dut%0d got stall=%0d flush=%0d want 5/0", d, stall_w[d], flush_w[d]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      drive_cycle($sformatf("saturate[%0d]", i), st(NOP, 0, 0, 1, 0, C_FRZ, C_FRZ, C_FRZ));
      if (i == 10) cnt_clear = 1'b1;
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ctrl_w[e.dut] !== e.ctrl)
          $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
        else n_pass++;
      end
      if (i == 10) begin
        n_checks++;
        if (stall_w[3] !== 32'd7 || stall_w[0] !== 32'd10)
          $display("FAIL saturate_value got dut3=%0d dut0=%0d want 7/10", stall_w[3], stall_w[0]);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    drive_cycle("after_clear", st(NOP, 0, 0, 1, 1, C_RUN, C_RUN, C_RUN));
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_w[e.dut] !== e.ctrl)
        $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
      else n_pass++;
    end
    n_checks++;
    if (stall_w[3] !== 32'd0 || stall_w[0] !== 32'd0)
      $display("FAIL clear_priority got dut3=%0d dut0=%0d want 0/0", stall_w[3], stall_w[0]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_bmiss_over_stall();
    stim_t tbl[3];
    exp_t  e;
    tbl[0] = st(LW_R1,  0, 0, 1, 1, C_RUN, C_RUN, C_RUN);
    tbl[1] = st(ADD_R1, 1, 0, 1, 1, C_BMS, C_BMS, C_BMS);
    tbl[2] = st(ADD_R1, 0, 0, 1, 1, C_RUN, C_DST, C_DST);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle($sformatf("bmiss[%0d]", i), tbl[i]);
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ctrl_w[e.dut] !== e.ctrl)
          $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (flush_w[d] !== 32'd1)
        $display("FAIL bmiss_flush_count dut%0d got %0d want 1", d, flush_w[d]);
      else n_pass++;
    end
  endtask

  task automatic test_jal();
    stim_t tbl[4];
    exp_t  e;
    tbl[0] = st(JAL_R3, 0, 1, 1, 1, C_JMS, C_JMS, C_JMS);
    tbl[1] = st(ADD_R3, 0, 0, 1, 1, C_RUN, C_DST, C_DST);
    tbl[2] = st(NOP,    0, 0, 0, 1, C_IWT, C_IWT, C_IWT);
    tbl[3] = st(ADD_R3, 0, 0, 1, 1, C_RUN, C_DST, C_RUN);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle($sformatf("jal[%0d]", i), tbl[i]);
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ctrl_w[e.dut] !== e.ctrl)
          $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (flush_w[d] !== 32'd1)
        $display("FAIL jal_flush_count dut%0d got %0d want 1", d, flush_w[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t tbl[3];
    exp_t  e;
    tbl[0] = st(LW_R1,  0, 0, 1, 1, C_RUN, C_RUN, C_RUN);
    tbl[1] = st(ADD_R1, 0, 0, 1, 1, C_DST, C_DST, C_DST);
    tbl[2] = st(ADD_R1, 0, 0, 1, 1, C_RUN, C_DST, C_DST);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle($sformatf("mid_reset[%0d]", i), tbl[i]);
      @(negedge clk);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ctrl_w[e.dut] !== e.ctrl)
          $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
        else n_pass++;
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    // Drop reset while dut1/dut2 are still stalling on the load.
    #1 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (ctrl_w[d] !== C_RST || stall_w[d] !== 32'd0)
        $display("FAIL mid_reset_hold dut%0d got ctrl=%b stall=%0d want %b/0", d, ctrl_w[d], stall_w[d], C_RST);
      else n_pass++;
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive_cycle("mid_reset_first", st(ADD_R1, 0, 0, 1, 1, C_RUN, C_RUN, C_RUN));
    @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (ctrl_w[e.dut] !== e.ctrl)
        $display("FAIL %s dut%0d ctrl got %b want %b", e.name, e.dut, ctrl_w[e.dut], e.ctrl);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_raw_nofwd();
    test_freeze();
    test_saturation();
    test_bmiss_over_stall();
    test_jal();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
